// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

    // Low bit of port k inside a packed multi-port vector of lane width w.
    function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write port bundle of the multi-port register file.
interface regfile_mp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
) ();
    logic [NUM_RD-1:0]        i_rd_en;
    logic [NUM_RD*ADDR_W-1:0] i_rd_addr;
    logic [NUM_RD*DATA_W-1:0] o_rd_data;
    logic                     i_we0;
    logic [ADDR_W-1:0]        i_waddr0;
    logic [DATA_W-1:0]        i_wdata0;
    logic                     i_we1;
    logic [ADDR_W-1:0]        i_waddr1;
    logic [DATA_W-1:0]        i_wdata1;
    logic                     o_ready;

    modport master (
        output i_rd_en, i_rd_addr, i_we0, i_waddr0, i_wdata0, i_we1, i_waddr1, i_wdata1,
        input  o_rd_data, o_ready
    );

    modport slave (
        input  i_rd_en, i_rd_addr, i_we0, i_waddr0, i_wdata0, i_we1, i_waddr1, i_wdata1,
        output o_rd_data, o_ready
    );
endinterface

// File: rtl/regfile_rd_port.sv
// One registered read port: zero-register masking, optional write bypass (REGFILE_BYPASS_EN).
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_mem_data,
`ifdef REGFILE_BYPASS_EN
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_waddr0,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_waddr1,
    input  logic [DATA_W-1:0] i_wdata1,
`endif
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] rd_data_c;

    // Port 1 takes priority over port 0 when forwarding, matching array write order.
    always_comb begin
        rd_data_c = i_mem_data;
`ifdef REGFILE_BYPASS_EN
        if (i_we1 && (i_waddr1 == i_rd_addr)) begin
            rd_data_c = i_wdata1;
        end else if (i_we0 && (i_waddr0 == i_rd_addr)) begin
            rd_data_c = i_wdata0;
        end
`endif
        if ((ZERO_REG != 0) && (i_rd_addr == '0)) begin
            rd_data_c = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_run) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= rd_data_c;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardware clear sequencer after reset.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input logic         i_clk,
    input logic         i_rst,
    regfile_mp_if.slave bus
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam logic [0:0]  INIT    = ST_INIT;
    localparam logic [0:0]  RUN     = ST_RUN;
    localparam logic        ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [0:0]        state_q;
    logic [0:0]        state_nxt;
    logic [ADDR_W-1:0] init_cnt_q;
    logic              ready_q;
    logic              run_c;
    logic              we0_c;
    logic              we1_c;

    assign run_c = (state_q == RUN) && !i_rst;
    assign we0_c = run_c && bus.i_we0 && !(ZERO_EN && (bus.i_waddr0 == '0));
    assign we1_c = run_c && bus.i_we1 && !(ZERO_EN && (bus.i_waddr1 == '0));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            INIT:    if (init_cnt_q == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            ready_q <= (state_nxt == RUN);
            if (state_q == INIT) begin
                init_cnt_q <= init_cnt_q + ADDR_W'(1);
            end
        end
    end

    // Clear sweep during INIT; in RUN port 1 is written last so it wins on a collision.
    always_ff @(posedge i_clk) begin
        if (!i_rst && (state_q == INIT)) begin
            mem[init_cnt_q] <= '0;
        end else begin
            if (we0_c) mem[bus.i_waddr0] <= bus.i_wdata0;
            if (we1_c) mem[bus.i_waddr1] <= bus.i_wdata1;
        end
    end

    assign bus.o_ready = ready_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        localparam int unsigned AOFS = slice_lo(k, ADDR_W);
        localparam int unsigned DOFS = slice_lo(k, DATA_W);

        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rd_q;

        assign addr = bus.i_rd_addr[AOFS +: ADDR_W];

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_run      (run_c),
            .i_rd_en    (bus.i_rd_en[k]),
            .i_rd_addr  (addr),
            .i_mem_data (mem[addr]),
`ifdef REGFILE_BYPASS_EN
            .i_we0      (we0_c),
            .i_waddr0   (bus.i_waddr0),
            .i_wdata0   (bus.i_wdata0),
            .i_we1      (we1_c),
            .i_waddr1   (bus.i_waddr1),
            .i_wdata1   (bus.i_wdata1),
`endif
            .o_rd_data  (rd_q)
        );

        assign bus.o_rd_data[DOFS +: DATA_W] = rd_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (4 read ports) against a cycle-level behavioural model.
module tb_regfile_mp;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NR    = 4;
    localparam int unsigned DEPTH = 32;

    logic i_clk = 1'b0;
    logic i_rst;

    always #5 i_clk = ~i_clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [DW-1:0] mdl_mem [DEPTH];
    logic [DW-1:0] exp_rd  [NR];
    logic          exp_ready;
    int            init_left;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural view of one clock edge given the inputs currently applied.
    task automatic model_edge();
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        if (i_rst) begin
            init_left = DEPTH;
            exp_ready = 1'b0;
            for (int k = 0; k < NR; k++) exp_rd[k] = '0;
            for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        end else if (init_left > 0) begin
            init_left--;
            exp_ready = (init_left == 0);
            for (int k = 0; k < NR; k++) exp_rd[k] = '0;
        end else begin
            exp_ready = 1'b1;
            for (int k = 0; k < NR; k++) begin
                if (bus.i_rd_en[k]) begin
                    a = bus.i_rd_addr[k*AW +: AW];
                    v = mdl_mem[a];
`ifdef REGFILE_BYPASS_EN
                    if (bus.i_we1 && bus.i_waddr1 == a) v = bus.i_wdata1;
                    else if (bus.i_we0 && bus.i_waddr0 == a) v = bus.i_wdata0;
`endif
                    if (a == 0) v = '0;
                    exp_rd[k] = v;
                end
            end
            if (bus.i_we0 && bus.i_waddr0 != 0) mdl_mem[bus.i_waddr0] = bus.i_wdata0;
            if (bus.i_we1 && bus.i_waddr1 != 0) mdl_mem[bus.i_waddr1] = bus.i_wdata1;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge i_clk);
        #1;
        check_eq("ready", DW'(bus.o_ready), DW'(exp_ready));
        for (int k = 0; k < NR; k++)
            check_eq($sformatf("rd%0d", k), bus.o_rd_data[k*DW +: DW], exp_rd[k]);
    endtask

    task automatic idle();
        bus.i_rd_en = '0;
        bus.i_we0   = 1'b0;
        bus.i_we1   = 1'b0;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        bus.i_rd_en[k]          = 1'b1;
        bus.i_rd_addr[k*AW +: AW] = a;
    endtask

    task automatic set_wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.i_we0 = 1'b1; bus.i_waddr0 = a; bus.i_wdata0 = d;
    endtask

    task automatic set_wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.i_we1 = 1'b1; bus.i_waddr1 = a; bus.i_wdata1 = d;
    endtask

    function automatic logic [DW-1:0] port(input int k);
        return bus.o_rd_data[k*DW +: DW];
    endfunction

    task automatic random_writes();
        bus.i_we0 = 1'($urandom); bus.i_waddr0 = AW'($urandom); bus.i_wdata0 = $urandom;
        bus.i_we1 = 1'($urandom); bus.i_waddr1 = AW'($urandom); bus.i_wdata1 = $urandom;
    endtask

    initial begin
        bus.i_rd_addr = '0; bus.i_waddr0 = '0; bus.i_wdata0 = '0;
        bus.i_waddr1 = '0; bus.i_wdata1 = '0;
        idle();
        init_left = 0;
        i_rst = 1'b1;
        step(); step();
        check_eq("rst_ready", DW'(bus.o_ready), '0);

        // Init sweep: ready low for exactly DEPTH cycles, writes ignored.
        i_rst = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            random_writes();
            for (int k = 0; k < NR; k++) set_rd(k, AW'($urandom));
            step();
        end
        check_eq("ready_after_init", DW'(bus.o_ready), 32'd1);
        idle();
        for (int g = 0; g < DEPTH / NR; g++) begin
            for (int k = 0; k < NR; k++) set_rd(k, AW'(g * NR + k));
            step();
            for (int k = 0; k < NR; k++) check_eq("cleared", port(k), '0);
        end

        // Basic write/read and zero register.
        idle(); set_wr0(5, 32'hDEADBEEF); step();
        idle(); set_rd(0, 5); step();
        check_eq("r5", port(0), 32'hDEADBEEF);
        idle(); set_wr0(0, 32'h12345678); step();
        idle(); set_rd(0, 0); step();
        check_eq("r0", port(0), '0);

        // Same-address collision and dual distinct writes.
        idle(); set_wr0(7, 32'h1111); set_wr1(7, 32'h2222); step();
        idle(); set_wr0(8, 32'h8888); set_wr1(9, 32'h9999); step();
        idle(); set_rd(0, 7); set_rd(1, 8); set_rd(2, 9); step();
        check_eq("r7_p1_wins", port(0), 32'h2222);
        check_eq("r8", port(1), 32'h8888);
        check_eq("r9", port(2), 32'h9999);

        // Read during write.
        idle(); set_wr0(3, 32'hAAAA); step();
        idle(); set_wr0(3, 32'hBBBB); set_rd(0, 3); step();
`ifdef REGFILE_BYPASS_EN
        check_eq("rdw_r3", port(0), 32'hBBBB);
`else
        check_eq("rdw_r3", port(0), 32'hAAAA);
`endif
        idle(); set_rd(0, 3); step();
        check_eq("r3_after", port(0), 32'hBBBB);

        // Hold with enable low; four ports distinct.
        idle(); set_wr0(11, 32'h0000_1234); set_wr1(12, 32'h0000_5678); step();
        idle(); set_rd(1, 11); step();
        idle(); bus.i_rd_addr[1*AW +: AW] = 12; step();
        check_eq("hold_p1", port(1), 32'h0000_1234);
        idle(); set_wr0(20, 32'hA0); set_wr1(21, 32'hA1); step();
        idle(); set_wr0(22, 32'hA2); set_wr1(23, 32'hA3); step();
        idle(); for (int k = 0; k < NR; k++) set_rd(k, AW'(20 + k)); step();
        for (int k = 0; k < NR; k++) check_eq("quad", port(k), DW'(32'hA0 + k));

        // Mid-operation reset re-clears the array.
        idle(); set_wr0(10, 32'h55); step();
        idle(); i_rst = 1'b1; step();
        i_rst = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            set_wr0(10, 32'h77); set_rd(0, 10);
            step();
        end
        idle(); set_rd(0, 10); step();
        check_eq("r10_cleared", port(0), '0);

        // Randomised traffic with clustered addresses to provoke collisions.
        for (int c = 0; c < 3000; c++) begin
            idle();
            bus.i_rd_en = NR'($urandom);
            for (int k = 0; k < NR; k++) bus.i_rd_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
            bus.i_we0 = 1'($urandom); bus.i_waddr0 = AW'($urandom_range(0, 7)); bus.i_wdata0 = $urandom;
            bus.i_we1 = 1'($urandom); bus.i_waddr1 = AW'($urandom_range(0, 7)); bus.i_wdata1 = $urandom;
            i_rst = ($urandom_range(0, 999) == 0);
            step();
        end
        i_rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
